// File: rtl/rot_unlock_ctrl_pkg.sv
// Shared definitions for the root-of-trust unlock controller:
// FSM state encoding, bus opcodes and default register map.
package rot_unlock_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_LOCKED,
      ST_LOAD,
      ST_COMPARE,
      ST_UNLOCKED,
      ST_LOCKOUT
   } state_t;

   localparam logic [31:0] OP_UNLOCK = 32'h1;
   localparam logic [31:0] OP_LOCK   = 32'h2;
   localparam logic [31:0] OP_ABORT  = 32'h3;

   localparam logic [31:0] OP_ADDR_DEF     = 32'h0;
   localparam logic [31:0] KEY_ADDR_DEF    = 32'h4;
   localparam logic [31:0] STATUS_ADDR_DEF = 32'h8;

endpackage

// File: rtl/rot_key_cmp.sv
// Constant-time key comparator: scans every chunk, MSB first,
// accumulating a sticky mismatch flag and pulsing done after the last.
module rot_key_cmp #(
   parameter int KEY_WIDTH = 128,
   parameter int CHUNK     = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic [KEY_WIDTH-1:0] key_buf,
   input  logic [KEY_WIDTH-1:0] key,
   output logic                 done,
   output logic                 mismatch
);

   localparam int NC = KEY_WIDTH / CHUNK;
   localparam int IW = (NC > 1) ? $clog2(NC) : 1;

   logic [IW-1:0]        idx;
   logic [KEY_WIDTH-1:0] buf_sh;
   logic [KEY_WIDTH-1:0] key_sh;

   assign buf_sh = key_buf << (CHUNK * idx);
   assign key_sh = key << (CHUNK * idx);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx      <= '0;
         done     <= 1'b0;
         mismatch <= 1'b0;
      end else if (!en) begin
         idx      <= '0;
         done     <= 1'b0;
         mismatch <= 1'b0;
      end else if (!done) begin
         mismatch <= mismatch |
                     (buf_sh[KEY_WIDTH-1 -: CHUNK] !=
                      key_sh[KEY_WIDTH-1 -: CHUNK]);
         idx      <= idx + 1'b1;
         done     <= (idx == IW'(NC - 1));
      end
   end

endmodule

// File: rtl/rot_unlock_ctrl.sv
// Obfuscation-unlock controller: bus decode, key word loader, unlock FSM,
// failed-attempt counter, lockout timer and registered status read-back.
module rot_unlock_ctrl
   import rot_unlock_ctrl_pkg::*;
#(
   parameter int                   WIDTH          = 32,
   parameter int                   KEY_WIDTH      = 128,
   parameter int                   CHUNK          = 8,
   parameter logic [KEY_WIDTH-1:0] KEY_DEFAULT    = {4{32'hF0F0AAAA}},
   parameter int                   MAX_ATTEMPTS   = 3,
   parameter int                   LOCKOUT_CYCLES = 1024,
   parameter logic [WIDTH-1:0]     OP_ADDR        = WIDTH'(OP_ADDR_DEF),
   parameter logic [WIDTH-1:0]     KEY_ADDR       = WIDTH'(KEY_ADDR_DEF),
   parameter logic [WIDTH-1:0]     STATUS_ADDR    = WIDTH'(STATUS_ADDR_DEF)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] data_i,
   input  logic [WIDTH-1:0] address,
   input  logic             re,
   input  logic             we,
   output logic [WIDTH-1:0] data_o,
   output logic             unlocked_o,
   output logic             busy_o,
   output logic             lockout_o
);

   localparam int NW  = KEY_WIDTH / WIDTH;
   localparam int WIW = (NW > 1) ? $clog2(NW) : 1;

   state_t               state;
   state_t               nxt;
   logic [WIW-1:0]       widx;
   logic [KEY_WIDTH-1:0] key_buf;
   logic [KEY_WIDTH-1:0] key_q;
   logic [7:0]           fail_cnt;
   logic [31:0]          lo_cnt;
   logic                 op_wr;
   logic                 key_wr;
   logic                 cmp_done;
   logic                 cmp_mism;
   logic                 lock_hit;
   logic                 lo_exit;

   assign key_q    = KEY_DEFAULT;
   assign op_wr    = we && (address == OP_ADDR);
   assign key_wr   = we && (address == KEY_ADDR);
   assign lock_hit = ({1'b0, fail_cnt} + 9'd1) == 9'(MAX_ATTEMPTS);
   assign lo_exit  = (LOCKOUT_CYCLES != 0) && (lo_cnt == '0);

   rot_key_cmp #(
      .KEY_WIDTH (KEY_WIDTH),
      .CHUNK     (CHUNK)
   ) u_cmp (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (state == ST_COMPARE),
      .key_buf  (key_buf),
      .key      (key_q),
      .done     (cmp_done),
      .mismatch (cmp_mism)
   );

   always_comb begin
      nxt = state;
      unique case (state)
         ST_LOCKED:
            if (op_wr && data_i == WIDTH'(OP_UNLOCK)) nxt = ST_LOAD;
         ST_LOAD:
            if (op_wr && data_i == WIDTH'(OP_ABORT)) nxt = ST_LOCKED;
            else if (key_wr && widx == WIW'(NW - 1)) nxt = ST_COMPARE;
         ST_COMPARE:
            if (cmp_done)
               nxt = !cmp_mism ? ST_UNLOCKED :
                     lock_hit  ? ST_LOCKOUT  : ST_LOCKED;
         ST_UNLOCKED:
            if (op_wr && data_i == WIDTH'(OP_LOCK)) nxt = ST_LOCKED;
            else if (op_wr && data_i == WIDTH'(OP_UNLOCK)) nxt = ST_LOAD;
         ST_LOCKOUT:
            if (lo_exit) nxt = ST_LOCKED;
         default: nxt = ST_LOCKED;
      endcase
   end

   // Outputs are decoded from the next state so they change with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_LOCKED;
         unlocked_o <= 1'b0;
         busy_o     <= 1'b0;
         lockout_o  <= 1'b0;
         widx       <= '0;
         key_buf    <= '0;
         fail_cnt   <= '0;
         lo_cnt     <= '0;
         data_o     <= '0;
      end else begin
         state      <= nxt;
         unlocked_o <= (nxt == ST_UNLOCKED);
         busy_o     <= (nxt == ST_LOAD) || (nxt == ST_COMPARE);
         lockout_o  <= (nxt == ST_LOCKOUT);

         if (nxt == ST_LOAD && state != ST_LOAD)
            widx <= '0;
         else if (state == ST_LOAD && key_wr)
            widx <= widx + 1'b1;

         if (state == ST_LOAD && key_wr)
            key_buf <= (key_buf << WIDTH) | KEY_WIDTH'(data_i);
         else if (state == ST_LOAD && nxt == ST_LOCKED)
            key_buf <= '0;
         else if (state == ST_COMPARE && cmp_done)
            key_buf <= '0;

         if (state == ST_COMPARE && cmp_done) begin
            if (!cmp_mism)
               fail_cnt <= '0;
            else if (fail_cnt != 8'hFF)
               fail_cnt <= fail_cnt + 8'd1;
         end else if (state == ST_LOCKOUT && lo_exit) begin
            fail_cnt <= '0;
         end

         if (nxt == ST_LOCKOUT && state != ST_LOCKOUT)
            lo_cnt <= 32'(LOCKOUT_CYCLES - 1);
         else if (state == ST_LOCKOUT && lo_cnt != '0)
            lo_cnt <= lo_cnt - 32'd1;

         if (re) begin
            if (address == STATUS_ADDR)
               data_o <= {busy_o, busy_o & (state == ST_COMPARE),
                          unlocked_o, lockout_o,
                          {(WIDTH-12){1'b0}}, fail_cnt};
            else
               data_o <= '0;
         end
      end
   end

endmodule

// File: tb/tb_rot_unlock_ctrl.sv
// Directed bench for rot_unlock_ctrl: vector table plus
// latency, lockout and asynchronous-reset sequences.
module tb_rot_unlock_ctrl;

   localparam logic [31:0] A_OP  = 32'h0;
   localparam logic [31:0] A_KEY = 32'h4;
   localparam logic [31:0] A_ST  = 32'h8;
   localparam logic [31:0] KW    = 32'hF0F0AAAA;
   localparam logic [31:0] KBAD  = 32'hF0F0AAAB;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] data_i = '0;
   logic [31:0] address = '0;
   logic        re = 1'b0;
   logic        we = 1'b0;
   logic [31:0] data_o;
   logic        unlocked_o;
   logic        busy_o;
   logic        lockout_o;

   int nvec = 0;
   int nfail = 0;

   typedef struct {
      logic        we;
      logic        re;
      logic [31:0] addr;
      logic [31:0] data;
      int          gap;
      logic        chk_d;
      logic [31:0] exp_d;
      logic [2:0]  exp_ubl;
   } vec_t;

   vec_t tbl[$];

   rot_unlock_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .data_i     (data_i),
      .address    (address),
      .re         (re),
      .we         (we),
      .data_o     (data_o),
      .unlocked_o (unlocked_o),
      .busy_o     (busy_o),
      .lockout_o  (lockout_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      we = 1'b1; address = a; data_i = d;
      @(posedge clk); #1;
      we = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a);
      @(negedge clk);
      re = 1'b1; address = a;
      @(posedge clk); #1;
      re = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic key_seq(input logic [31:0] last);
      wr(A_OP, 32'h1);
      repeat (3) wr(A_KEY, KW);
      wr(A_KEY, last);
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy_o && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   function automatic vec_t mk(input logic w, input logic r,
                               input logic [31:0] a, input logic [31:0] d,
                               input int g, input logic c,
                               input logic [31:0] e, input logic [2:0] u);
      vec_t v;
      v.we = w; v.re = r; v.addr = a; v.data = d;
      v.gap = g; v.chk_d = c; v.exp_d = e; v.exp_ubl = u;
      return v;
   endfunction

   initial begin
      int n;
      string nm;

      // {we,re,addr,data,gap,chk_d,exp_d,{unlocked,busy,lockout}}
      tbl.push_back(mk(0, 1, A_ST,  0,     0,  1, 32'h0,         3'b000));
      tbl.push_back(mk(1, 0, A_OP,  1,     0,  0, 0,             3'b010));
      tbl.push_back(mk(0, 1, A_ST,  0,     0,  1, 32'h8000_0000, 3'b010));
      tbl.push_back(mk(1, 0, A_KEY, KW,    0,  0, 0,             3'b010));
      tbl.push_back(mk(1, 0, A_KEY, KW,    0,  0, 0,             3'b010));
      tbl.push_back(mk(1, 0, A_KEY, KW,    0,  0, 0,             3'b010));
      tbl.push_back(mk(1, 0, A_KEY, KW,    0,  0, 0,             3'b010));
      tbl.push_back(mk(0, 1, A_ST,  0,     0,  1, 32'hC000_0000, 3'b010));
      tbl.push_back(mk(0, 0, A_ST,  0,     20, 0, 0,             3'b100));
      tbl.push_back(mk(0, 1, A_ST,  0,     0,  1, 32'h2000_0000, 3'b100));
      tbl.push_back(mk(0, 1, A_KEY, 0,     0,  1, 32'h0,         3'b100));
      tbl.push_back(mk(0, 1, A_ST,  0,     0,  1, 32'h2000_0000, 3'b100));
      tbl.push_back(mk(0, 1, A_OP,  0,     0,  1, 32'h0,         3'b100));
      tbl.push_back(mk(1, 0, A_KEY, 32'h5, 0,  0, 0,             3'b100));
      tbl.push_back(mk(1, 0, A_OP,  2,     0,  0, 0,             3'b000));
      tbl.push_back(mk(1, 0, A_OP,  3,     0,  0, 0,             3'b000));
      tbl.push_back(mk(1, 0, A_KEY, KW,    0,  0, 0,             3'b000));
      tbl.push_back(mk(1, 0, A_OP,  1,     0,  0, 0,             3'b010));
      tbl.push_back(mk(1, 0, A_KEY, KW,    0,  0, 0,             3'b010));
      tbl.push_back(mk(1, 0, A_KEY, KW,    0,  0, 0,             3'b010));
      tbl.push_back(mk(1, 0, A_KEY, KW,    0,  0, 0,             3'b010));
      tbl.push_back(mk(1, 0, A_KEY, KBAD,  20, 0, 0,             3'b000));
      tbl.push_back(mk(0, 1, A_ST,  0,     0,  1, 32'h0000_0001, 3'b000));
      tbl.push_back(mk(1, 0, A_OP,  1,     0,  0, 0,             3'b010));
      tbl.push_back(mk(1, 0, A_KEY, KW,    0,  0, 0,             3'b010));
      tbl.push_back(mk(1, 0, A_OP,  3,     0,  0, 0,             3'b000));
      tbl.push_back(mk(0, 1, A_ST,  0,     0,  1, 32'h0000_0001, 3'b000));
      tbl.push_back(mk(0, 1, 32'h10, 0,    0,  1, 32'h0,         3'b000));

      do_reset();
      chk("reset_outputs", {29'd0, unlocked_o, busy_o, lockout_o}, 32'h0);

      foreach (tbl[i]) begin
         @(negedge clk);
         we = tbl[i].we; re = tbl[i].re;
         address = tbl[i].addr; data_i = tbl[i].data;
         @(posedge clk); #1;
         we = 1'b0; re = 1'b0;
         repeat (tbl[i].gap) @(posedge clk);
         #1;
         nm = $sformatf("vec%0d_ubl", i);
         chk(nm, {29'd0, unlocked_o, busy_o, lockout_o},
             {29'd0, tbl[i].exp_ubl});
         if (tbl[i].chk_d) begin
            nm = $sformatf("vec%0d_data", i);
            chk(nm, data_o, tbl[i].exp_d);
         end
      end

      // pass and fail take the same number of cycles
      do_reset();
      key_seq(KW);
      wait_idle(n);
      chk("pass_latency", n, 17);
      chk("pass_unlocked", {31'd0, unlocked_o}, 32'h1);
      wr(A_OP, 32'h1);
      chk("reauth_outs", {29'd0, unlocked_o, busy_o, lockout_o}, 32'h2);
      wr(A_OP, 32'h3);
      key_seq(KBAD);
      wait_idle(n);
      chk("fail_latency", n, 17);
      rd(A_ST);
      chk("fail_status", data_o, 32'h0000_0001);

      // three consecutive failures lock out for LOCKOUT_CYCLES
      do_reset();
      for (int k = 0; k < 3; k++) begin
         key_seq(KBAD);
         wait_idle(n);
         nm = $sformatf("lockout_after_%0d", k + 1);
         chk(nm, {31'd0, lockout_o}, (k == 2) ? 32'h1 : 32'h0);
      end
      wr(A_OP, 32'h1);
      chk("lockout_ignores_op", {29'd0, unlocked_o, busy_o, lockout_o},
          32'h1);
      n = 1;
      while (lockout_o && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      chk("lockout_cycles", n, 1024);
      rd(A_ST);
      chk("post_lockout_status", data_o, 32'h0);
      key_seq(KW);
      wait_idle(n);
      chk("post_lockout_unlock", {31'd0, unlocked_o}, 32'h1);

      // asynchronous reset in the middle of a compare
      do_reset();
      key_seq(KW);
      repeat (5) @(posedge clk);
      #1;
      chk("mid_cmp_busy", {31'd0, busy_o}, 32'h1);
      rst_n = 1'b0;
      #1;
      chk("async_reset_outs", {29'd0, unlocked_o, busy_o, lockout_o},
          32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      rd(A_ST);
      chk("after_reset_status", data_o, 32'h0);
      key_seq(KW);
      wait_idle(n);
      chk("after_reset_latency", n, 17);
      chk("after_reset_unlock", {31'd0, unlocked_o}, 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
